// File: rtl/mole_game_controller.sv
// rtl/mole_game_controller.sv - whack-a-mole game FSM: mole selection, exposure timing, scoring and lives.
module mole_game_controller #(
  parameter int         NUM_MOLES  = 5,
  parameter int         SHOW_TICKS = 2,
  parameter int         GAP_TICKS  = 1,
  parameter int         LIVES      = 3,
  parameter int         SCORE_W    = 8,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 startPulse,
  input  logic [NUM_MOLES-1:0] hitPulse,
  output logic [NUM_MOLES-1:0] moleLED,
  output logic [SCORE_W-1:0]   score,
  output logic [2:0]           livesLeft,
  output logic                 gameOver,
  output logic                 active
);

  localparam int IDX_W   = $clog2(NUM_MOLES);
  localparam int CNT_MAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_SHOW, ST_OVER} state_t;

  state_t               state_q, state_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [IDX_W-1:0]     prev_idx_q, prev_idx_d;
  logic [IDX_W-1:0]     cand_idx, next_idx;
  logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [NUM_MOLES-1:0] mole_q, mole_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [2:0]           lives_q, lives_d;
  logic                 target_hit, wrong_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= LFSR_SEED;
      prev_idx_q <= '0;
      tick_cnt_q <= '0;
      mole_q     <= '0;
      score_q    <= '0;
      lives_q    <= 3'(LIVES);
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      prev_idx_q <= prev_idx_d;
      tick_cnt_q <= tick_cnt_d;
      mole_q     <= mole_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
    end
  end

  // Bump the candidate by one when it repeats the last mole so no mole is shown twice in a row.
  always_comb begin
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    cand_idx = IDX_W'(lfsr_q % 8'(NUM_MOLES));
    next_idx = cand_idx;
    if (cand_idx == prev_idx_q) begin
      next_idx = (cand_idx == IDX_W'(NUM_MOLES - 1)) ? '0 : cand_idx + IDX_W'(1);
    end
    target_hit = |(hitPulse & mole_q);
    wrong_hit  = (|hitPulse) && !target_hit;
  end

  always_comb begin
    state_d    = state_q;
    prev_idx_d = prev_idx_q;
    tick_cnt_d = tick_cnt_q;
    mole_d     = mole_q;
    score_d    = score_q;
    lives_d    = lives_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (startPulse) begin
          state_d    = ST_GAP;
          score_d    = '0;
          lives_d    = 3'(LIVES);
          tick_cnt_d = '0;
          mole_d     = '0;
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (tick_cnt_q + CNT_W'(1) == CNT_W'(GAP_TICKS)) begin
            state_d    = ST_SHOW;
            mole_d     = {{(NUM_MOLES-1){1'b0}}, 1'b1} << next_idx;
            prev_idx_d = next_idx;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SHOW: begin
        if (target_hit) begin
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
          mole_d     = '0;
          tick_cnt_d = '0;
          state_d    = ST_GAP;
        end else if (wrong_hit) begin
          lives_d = lives_q - 3'd1;
          if (lives_q == 3'd1) begin
            state_d = ST_OVER;
            mole_d  = '0;
          end
        end else if (tick) begin
          if (tick_cnt_q + CNT_W'(1) == CNT_W'(SHOW_TICKS)) begin
            lives_d    = lives_q - 3'd1;
            mole_d     = '0;
            tick_cnt_d = '0;
            state_d    = (lives_q == 3'd1) ? ST_OVER : ST_GAP;
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign moleLED   = mole_q;
  assign score     = score_q;
  assign livesLeft = lives_q;
  assign gameOver  = (state_q == ST_OVER);
  assign active    = (state_q == ST_GAP) || (state_q == ST_SHOW);

endmodule

// File: doc/mole_game_controller.md
Name: mole_game_controller

Overview:
- Core game FSM of the whack-a-mole design.
- Sits directly downstream of the clock-divider stage: consumes the slow game tick plus debounced start/mole button pulses, and drives the 5 mole LEDs.
- Picks a pseudo-random mole, times its exposure in ticks, scores hits, deducts lives on misses/timeouts, and ends the game when lives run out.
- Score/lives outputs feed the segment-display stage.

Parameters:
- NUM_MOLES, 5, number of mole buttons/LEDs (2..8).
- SHOW_TICKS, 2, ticks a mole stays lit before counting as a timeout miss (>=1).
- GAP_TICKS, 1, ticks of dark gap between moles (>=1).
- LIVES, 3, lives at game start (1..7).
- SCORE_W, 8, score counter width.
- LFSR_SEED, 8'hA5, nonzero LFSR reset value.

Ports:
- clock  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  single-cycle enable pulse from the clock divider (1 Hz nominal), synchronous to clock.
- startPulse  input  1  debounced single-cycle start press.
- hitPulse  input  NUM_MOLES  debounced single-cycle mole button presses, bit i = mole i.
- moleLED  output  NUM_MOLES  one-hot lit mole, registered.
- score  output  SCORE_W  hits this game, registered.
- livesLeft  output  3  remaining lives, registered.
- gameOver  output  1  high while in GAME_OVER.
- active  output  1  high in GAP or SHOW.

Behaviour:
Reset (sampled on rising clock edge while reset=1):
- state=IDLE, moleLED=0, score=0, livesLeft=LIVES, gameOver=0, active=0.
- lfsr=LFSR_SEED, prevIdx=0, tickCnt=0.
- Reset mid-game aborts immediately to these values. There is no partial state.

LFSR:
- 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
- Advances every clock cycle when not in reset.
- Candidate idx = lfsr mod NUM_MOLES. If idx == prevIdx, use (idx+1) mod NUM_MOLES, so the same mole never appears twice in a row.

States:
- IDLE:
  - All outputs dark.
  - startPulse -> GAP; score:=0, livesLeft:=LIVES, tickCnt:=0.
- GAP:
  - moleLED=0.
  - Each tick increments tickCnt.
  - On the tick making tickCnt==GAP_TICKS -> SHOW. On that same edge: moleLED:=one-hot(idx), prevIdx:=idx, tickCnt:=0.
- SHOW (evaluated each cycle, in priority order):
  1. hitPulse[target]=1 (correct bit set, other bits ignored) -> score:=score+1, saturating at all-ones; moleLED:=0; tickCnt:=0; -> GAP.
  2. Else hitPulse!=0 (wrong mole only) -> livesLeft-1; mole stays lit; tickCnt unchanged.
  3. Else tick and tickCnt+1==SHOW_TICKS -> livesLeft-1; moleLED:=0; tickCnt:=0; -> GAP.
  4. Else tick -> tickCnt+1.
  - A hit in the same cycle as the expiring tick counts as a hit.
  - Any decrement that makes livesLeft 0 -> GAME_OVER (moleLED:=0) instead of GAP/SHOW.
- GAME_OVER:
  - gameOver=1, moleLED=0, score held, livesLeft=0.
  - startPulse -> GAP with score:=0, livesLeft:=LIVES.

Input handling:
- hitPulse is ignored in IDLE, GAP and GAME_OVER.
- startPulse is ignored in GAP and SHOW.

Timing:
- All outputs are registered.
- Effects of an input pulse are visible on outputs the cycle after the pulse is sampled (1-cycle latency).
- livesLeft never underflows below 0.

Test Plan (params default; tick driven every 4 clocks unless stated):
1. Reset: hold reset 3 cycles, then release -> moleLED=0, score=0, livesLeft=3, gameOver=0, active=0. Ticks without startPulse -> state remains IDLE.
2. Start and hit:
   - Pulse startPulse -> active=1 next cycle.
   - After 1 tick, moleLED is exactly one-hot.
   - Pulse the matching hitPulse bit -> next cycle moleLED=0, score=1.
   - After the next tick, the new moleLED differs from the previous one.
3. Timeout: in SHOW, apply no hits for 2 ticks -> moleLED=0 and livesLeft=2 the cycle after the 2nd tick; play continues.
4. Wrong button, then game over:
   - In SHOW, pulse a non-target bit 3 times -> livesLeft goes 2, 1, 0.
   - After the 3rd pulse: gameOver=1, moleLED=0, active=0.
   - Further hitPulse -> no change.
   - startPulse -> score=0, livesLeft=3, active=1.
5. Simultaneous events:
   - Assert the target hitPulse together with a wrong bit and the expiring 2nd tick in the same cycle -> score+1, livesLeft unchanged.
   - startPulse during SHOW is ignored.
6. Saturation and reset mid-operation:
   - With SCORE_W=2, score 4 hits -> score stays 3.
   - Assert reset while in SHOW -> next cycle all outputs at reset values.
